// File: rtl/vga_plot_scanout.sv
// vga_plot_scanout
// ----------------
// Display-side endpoint for the game datapath. Pixel writes land in a
// 160x120, 3-bit framebuffer. The framebuffer is scanned out continuously
// as 640x480@60 VGA, with each framebuffer pixel replicated 4x4. The block
// also emits a one-clock frame pulse for pacing animation.
//
// Configuration macro:
//   VGA_PLOT_BOUNDS_CHECK_EN - when defined, writes with x>=160 or y>=120
//                              are discarded. When undefined, the raw
//                              computed address is used: x>=160 aliases into
//                              the next row, and addresses >=19200 are dropped.
//
// Ports:
//   clk          in   50 MHz system clock (only clock)
//   resetn       in   asynchronous active-low reset
//   x[7:0]       in   write column (0..159)
//   y[6:0]       in   write row (0..119)
//   color[2:0]   in   write colour {R,G,B}
//   plot         in   write strobe, one pixel per clock, no backpressure
//   vga_clk      out  25 MHz pixel clock (the internal pixel-tick register)
//   vga_hs       out  horizontal sync, active low
//   vga_vs       out  vertical sync, active low
//   vga_blank_n  out  high while in the visible region
//   vga_sync_n   out  tied low
//   vga_r/g/b    out  colour bit expanded to 8'hFF / 8'h00
//   frame_start  out  one-clock pulse at the start of vertical blanking

module vga_plot_scanout #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] color,
  input  logic       plot,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       frame_start
);

  localparam int FB_DEPTH = 19200;
  localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS_W    = 10'(H_VIS);
  localparam logic [9:0]  V_VIS_W    = 10'(V_VIS);
  localparam logic [9:0]  HS_FIRST   = 10'(H_VIS + H_FP);
  localparam logic [9:0]  HS_LAST    = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_FIRST   = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VS_LAST    = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [14:0] FB_DEPTH_W = 15'd19200;

  // row*160 + col, built from shifts so no multiplier is needed.
  function automatic logic [14:0] fbAddr(input logic [6:0] row, input logic [7:0] col);
    fbAddr = {1'b0, row, 7'd0} + {3'd0, row, 5'd0} + {7'd0, col};
  endfunction

  logic [2:0]  fb [0:FB_DEPTH-1];

  logic        pixTick;
  logic [9:0]  hCnt;
  logic [9:0]  vCnt;
  logic [9:0]  hNext;
  logic [9:0]  vNext;

  logic [14:0] wrAddr;
  logic        wrEn;
  logic [14:0] rdAddr;
  logic [2:0]  rdData;

  logic        visS;
  logic        hsS;
  logic        vsS;
  logic        fsS;

  // Stage-1 copies of the timing signals, aligned with rdData.
  logic        visD;
  logic        hsD;
  logic        vsD;
  logic        fsD;

  assign vga_clk    = pixTick;
  assign vga_sync_n = 1'b0;

  // Write-side address and enable (optionally bounds-checked).
  always_comb begin
    wrAddr = fbAddr(y, x);
    wrEn   = 1'b0;
`ifdef VGA_PLOT_BOUNDS_CHECK_EN
    if (plot && (x < 8'd160) && (y < 7'd120)) begin
      wrEn = 1'b1;
    end else begin
      wrEn = 1'b0;
    end
`else
    if (plot && (wrAddr < FB_DEPTH_W)) begin
      wrEn = 1'b1;
    end else begin
      wrEn = 1'b0;
    end
`endif
  end

  // Framebuffer write port; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      fb[wrAddr] <= color;
    end
  end

  // Framebuffer read port; one clock of latency, old data on a same-address write.
  always_ff @(posedge clk) begin
    rdData <= fb[rdAddr];
  end

  // Raster counter next-state: move only on pixel-tick clocks.
  always_comb begin
    hNext = hCnt;
    vNext = vCnt;
    if (pixTick) begin
      if (hCnt == H_LAST) begin
        hNext = 10'd0;
        if (vCnt == V_LAST) begin
          vNext = 10'd0;
        end else begin
          vNext = vCnt + 10'd1;
        end
      end else begin
        hNext = hCnt + 10'd1;
        vNext = vCnt;
      end
    end else begin
      hNext = hCnt;
      vNext = vCnt;
    end
  end

  // Pixel tick and raster counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pixTick <= 1'b0;
      hCnt    <= 10'd0;
      vCnt    <= 10'd0;
    end else begin
      pixTick <= ~pixTick;
      hCnt    <= hNext;
      vCnt    <= vNext;
    end
  end

  // Decode of the current raster position. The frame pulse qualifies on
  // pixTick==0, which is the first of the two clocks the counters sit at
  // (0, V_VIS), so it lasts a single clock.
  always_comb begin
    visS = (hCnt < H_VIS_W) && (vCnt < V_VIS_W);
    hsS  = !((hCnt >= HS_FIRST) && (hCnt <= HS_LAST));
    vsS  = !((vCnt >= VS_FIRST) && (vCnt <= VS_LAST));
    fsS  = (hCnt == 10'd0) && (vCnt == V_VIS_W) && !pixTick;
    if (visS) begin
      rdAddr = fbAddr(vCnt[8:2], hCnt[9:2]);
    end else begin
      rdAddr = 15'd0;
    end
  end

  // Stage 1: delay the timing decode by the read latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      visD <= 1'b0;
      hsD  <= 1'b1;
      vsD  <= 1'b1;
      fsD  <= 1'b0;
    end else begin
      visD <= visS;
      hsD  <= hsS;
      vsD  <= vsS;
      fsD  <= fsS;
    end
  end

  // Stage 2: registered pins, all showing the position from 2 clocks earlier.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      vga_hs      <= hsD;
      vga_vs      <= vsD;
      vga_blank_n <= visD;
      vga_r       <= visD ? {8{rdData[2]}} : 8'h00;
      vga_g       <= visD ? {8{rdData[1]}} : 8'h00;
      vga_b       <= visD ? {8{rdData[0]}} : 8'h00;
      frame_start <= fsD;
    end
  end

endmodule

// File: doc/vga_plot_scanout.md
# vga_plot_scanout

Display-side endpoint for the game datapath's pixel stream. Accepts one `(x, y, color, plot)` write per clock into an internal 160x120, 3-bit framebuffer. Continuously scans that framebuffer out as 640x480@60 Hz VGA with 4x4 pixel replication. Sits between the game datapath/FSM and the DE1 video DAC pins. It also supplies a per-frame pulse for animation pacing.

## Interface
Parameters:
- `H_VIS` 640, `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal timing, in pixel ticks.
- `V_VIS` 480, `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical timing, in lines.

Ports:
- `clk`  in  1  50 MHz system clock; the only clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `x`  in  8  write column, valid range 0..159.
- `y`  in  7  write row, valid range 0..119.
- `color`  in  3  write colour as {R,G,B}.
- `plot`  in  1  write strobe; one pixel is written per cycle while high; there is no backpressure.
- `vga_clk`  out  1  pixel clock, equal to the internal `pix_tick` register.
- `vga_hs`, `vga_vs`  out  1  sync outputs, active low.
- `vga_blank_n`  out  1  high during the visible region.
- `vga_sync_n`  out  1  constant 0.
- `vga_r`, `vga_g`, `vga_b`  out  8  each is its colour bit replicated to 8'hFF or 8'h00.
- `frame_start`  out  1  one-clk pulse at the start of vertical blanking.

## Operation
Write side:
- When `plot`=1 on a clk edge, `fb[y*160 + x] <= color`.
- The address is computed as `(y<<7)+(y<<5)+x` in 15 bits.
- The write is visible to the read port from the next edge.
- A read of the same address in the same cycle returns the old data.

Pixel tick:
- `pix_tick` toggles every clk.
- The counters advance only on edges where `pix_tick`=1, giving a 25 MHz pixel rate.

Counters:
- `h_cnt` counts 0..799, then wraps to 0.
- `v_cnt` increments when `h_cnt` wraps; it counts 0..524, then wraps to 0.

Scanout:
- Read address = `(v_cnt>>2)*160 + (h_cnt>>2)`; it is used only while visible (`h_cnt`<640 and `v_cnt`<480).
- Visible region: `vga_blank_n`=1 and the RGB outputs come from framebuffer data.
- Outside the visible region: RGB = 0.
- `vga_hs`=0 for `h_cnt` in [656,751].
- `vga_vs`=0 for `v_cnt` in [490,491].

`frame_start`:
- Pulses for exactly one clk when the counters reach `h_cnt`=0, `v_cnt`=480.
- There is one pulse per frame.

Reset:
- Applies asynchronously.
- `h_cnt`=`v_cnt`=0 and `pix_tick`=0.
- `vga_hs`=`vga_vs`=1, `vga_blank_n`=0, RGB=0, `frame_start`=0.
- Framebuffer contents are not cleared. After reset release, scanning restarts at (0,0).

Simultaneous events:
- A write and a scanout read of the same address are independent.
- `plot` during blanking is accepted normally.

## Timing
- Framebuffer read latency is 1 clk.
- Sync and blank are delayed to match the read data.
- All `vga_*` outputs are registered.
- Pins reflect counter position (h,v) exactly 2 clk after the counters take that value. All outputs stay aligned to each other.
- Frame period = 2*800*525 = 840000 clk.
- `vga_hs` low width = 192 clk.
- `vga_vs` low width = 2 lines = 3200 clk.
- The first clk edge after `resetn` deassertion advances `pix_tick` to 1. The counters leave (0,0) on the next edge.

## Configuration
- `VGA_PLOT_BOUNDS_CHECK_EN` defined: writes with x≥160 or y≥120 are discarded and the framebuffer is unchanged.
- `VGA_PLOT_BOUNDS_CHECK_EN` undefined: the write uses the raw computed address.
  - x≥160 aliases into the following row.
  - Any computed address ≥19200 is silently dropped because there is no storage there.

## Test plan
- Reset: assert `resetn`=0 mid-frame → immediately hs=vs=1, blank_n=0, rgb=0, frame_start=0. After release, the first hs falling edge occurs 2*656+2 clk later.
- Sync timing: free-run one frame.
  - hs low 192 clk every 1600 clk.
  - vs low 3200 clk.
  - frame_start pulses 1 clk, exactly 840000 clk apart.
  - blank_n high 1280 clk per visible line and 480 lines per frame.
- Plot/readback: plot (x=5,y=3,color=3'b101).
  - Pins show r=8'hFF, g=8'h00, b=8'hFF for h=20..23, v=12..15.
  - Neighbouring pixels are unchanged.
- Back-to-back writes: plot 160 consecutive cycles across row 0 with color=3'b010 → the next frame line v=0..3 is all green.
- Bounds, with `VGA_PLOT_BOUNDS_CHECK_EN`: plot (x=165,y=0,color=3'b111) → pixel (5,1) is unchanged.
- Bounds, without `VGA_PLOT_BOUNDS_CHECK_EN`: the same plot → pixel (5,1) displays white.
